// File: rtl/tour_pkg.sv
// Shared constants for the knight's-tour move sequencer: FSM encodings,
// command opcodes/headings, response bytes and move-to-command helpers.
package tour_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_VERT   = 3'd2;
    localparam logic [2:0] ST_WAIT_V = 3'd3;
    localparam logic [2:0] ST_HORZ   = 3'd4;
    localparam logic [2:0] ST_WAIT_H = 3'd5;

    // Command opcodes
    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_MOVE_FF = 4'h5;

    // Headings
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Response bytes back to the BLE side
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // True when exactly one bit of v is set (8'h00 is not one-hot)
    function automatic logic is_one_hot(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

    // Vertical leg for move bit b: N when dy > 0, S otherwise, length |dy|
    function automatic logic [15:0] vert_cmd(input int b);
        logic [15:0] c;
        case (b)
            0, 1:    c = {OP_MOVE, HDG_N, 4'd2};
            2, 7:    c = {OP_MOVE, HDG_N, 4'd1};
            3, 6:    c = {OP_MOVE, HDG_S, 4'd1};
            default: c = {OP_MOVE, HDG_S, 4'd2};
        endcase
        return c;
    endfunction

    // Horizontal leg for move bit b: E when dx > 0, W otherwise, length |dx|
    function automatic logic [15:0] horz_cmd(input int b);
        logic [15:0] c;
        case (b)
            0, 5:    c = {OP_MOVE_FF, HDG_E, 4'd1};
            1, 4:    c = {OP_MOVE_FF, HDG_W, 4'd1};
            2, 3:    c = {OP_MOVE_FF, HDG_W, 4'd2};
            default: c = {OP_MOVE_FF, HDG_E, 4'd2};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/knight_move_dec.sv
// Combinational decode of a one-hot knight move into its vertical and
// horizontal motion commands, plus a one-hot legality flag.
module knight_move_dec
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] v_cmd,
    output logic [15:0] h_cmd,
    output logic        legal
);

    logic [15:0] v_terms [8];
    logic [15:0] h_terms [8];

    // Each move bit contributes its own constant command; with a one-hot
    // input exactly one term is non-zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            localparam logic [15:0] V_CONST = vert_cmd(gi);
            localparam logic [15:0] H_CONST = horz_cmd(gi);
            assign v_terms[gi] = move[gi] ? V_CONST : 16'h0000;
            assign h_terms[gi] = move[gi] ? H_CONST : 16'h0000;
        end
    endgenerate

    // OR-reduce the per-bit terms into the two leg commands
    always_comb begin
        v_cmd = 16'h0000;
        h_cmd = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            v_cmd = v_cmd | v_terms[i];
            h_cmd = h_cmd | h_terms[i];
        end
    end

    assign legal = is_one_hot(move);

endmodule

// File: rtl/tour_move_seq.sv
// Tour move sequencer: walks the solved move list, turns each knight move
// into a vertical then horizontal command for cmd_proc, and passes UART
// commands straight through while no tour is running.
module tour_move_seq
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    logic [2:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       mv_q_reg, mv_q_next;
    logic             tour_err_reg, tour_err_next;

    logic [15:0] v_cmd, h_cmd;
    logic        mv_legal;
    logic        last_move;

    knight_move_dec u_dec (
        .move  (mv_q_reg),
        .v_cmd (v_cmd),
        .h_cmd (h_cmd),
        .legal (mv_legal)
    );

    assign last_move = (idx_reg == LAST_IDX);

    // State, index, latched move and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            mv_q_reg     <= 8'h00;
            tour_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            mv_q_reg     <= mv_q_next;
            tour_err_reg <= tour_err_next;
        end
    end

    // Next-state logic: the handshake with cmd_proc paces each leg
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        mv_q_next     = mv_q_reg;
        tour_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_tour) begin
                    idx_next   = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Legality is judged on the incoming move so an illegal
                // entry aborts before any command is issued.
                mv_q_next = move;
                if (is_one_hot(move)) begin
                    state_next = ST_VERT;
                end else begin
                    tour_err_next = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            ST_VERT: begin
                if (clr_cmd_rdy) state_next = ST_WAIT_V;
            end
            ST_WAIT_V: begin
                if (send_resp) state_next = ST_HORZ;
            end
            ST_HORZ: begin
                if (clr_cmd_rdy) state_next = ST_WAIT_H;
            end
            ST_WAIT_H: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output mux: UART passthrough in IDLE, tour commands otherwise
    always_comb begin
        cmd     = v_cmd;
        cmd_rdy = 1'b0;
        resp    = RESP_BUSY;
        case (state_reg)
            ST_IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
            end
            ST_VERT: begin
                cmd     = v_cmd;
                cmd_rdy = mv_legal;
            end
            ST_WAIT_V: begin
                cmd = v_cmd;
            end
            ST_HORZ: begin
                cmd     = h_cmd;
                cmd_rdy = mv_legal;
            end
            ST_WAIT_H: begin
                cmd  = h_cmd;
                // The final move's completion reports done, not busy
                resp = last_move ? RESP_DONE : RESP_BUSY;
            end
            default: begin
                cmd = v_cmd;
            end
        endcase
    end

    assign mv_indx  = idx_reg;
    assign tour_err = tour_err_reg;

endmodule
